// File: rtl/simd_result_serializer.sv
// simd_result_serializer
// Captures one packed SIMD result vector and replays it as scalar writeback
// beats, one enabled lane per beat, lowest lane first. Skipped lanes cost no
// cycles. A one-cycle vec_done pulse marks the end of each vector.
//
// Optional build macro: SIMD_SER_STICKY_FLAGS_EN
//   Adds vec_any_overflow / vec_any_carry / vec_any_negative / vec_all_zero,
//   summarising the flags of the written lanes and valid only with vec_done.
module simd_result_serializer #(
  parameter int DATA_WIDTH     = 32,
  parameter int SIMD_WIDTH     = 4,
  parameter int REG_ADDR_WIDTH = 5,
  localparam int LANE_W        = $clog2(SIMD_WIDTH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SIMD_WIDTH*DATA_WIDTH-1:0] in_result,
  input  logic [SIMD_WIDTH-1:0]            in_zero,
  input  logic [SIMD_WIDTH-1:0]            in_overflow,
  input  logic [SIMD_WIDTH-1:0]            in_carry_out,
  input  logic [SIMD_WIDTH-1:0]            in_negative,
  input  logic [SIMD_WIDTH-1:0]            in_lane_mask,
  input  logic [REG_ADDR_WIDTH-1:0]        in_rd_base,
  output logic                             wb_valid,
  input  logic                             wb_ready,
  output logic [DATA_WIDTH-1:0]            wb_data,
  output logic [REG_ADDR_WIDTH-1:0]        wb_rd,
  output logic [LANE_W-1:0]                wb_lane,
  output logic [3:0]                       wb_flags,
  output logic                             vec_done,
  output logic                             busy
`ifdef SIMD_SER_STICKY_FLAGS_EN
  ,
  output logic                             vec_any_overflow,
  output logic                             vec_any_carry,
  output logic                             vec_any_negative,
  output logic                             vec_all_zero
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [SIMD_WIDTH*DATA_WIDTH-1:0] result_reg;
  logic [SIMD_WIDTH-1:0]            zero_reg;
  logic [SIMD_WIDTH-1:0]            overflow_reg;
  logic [SIMD_WIDTH-1:0]            carry_reg;
  logic [SIMD_WIDTH-1:0]            negative_reg;
  logic [SIMD_WIDTH-1:0]            mask_reg;   // lanes still to be written
  logic [REG_ADDR_WIDTH-1:0]        rd_base_reg;

  logic                  capture;
  logic                  beat;
  logic                  draining;
  logic [SIMD_WIDTH-1:0] mask_clr;             // remaining mask minus its lowest set bit
  logic [LANE_W-1:0]     cur_lane;

  logic [DATA_WIDTH-1:0] lane_data  [SIMD_WIDTH];
  logic [3:0]            lane_flags [SIMD_WIDTH];

  // Unpack per-lane result words and flag nibbles {n, c, v, z}
  genvar gi;
  generate
    for (gi = 0; gi < SIMD_WIDTH; gi++) begin : g_lane
      assign lane_data[gi]  = result_reg[gi*DATA_WIDTH +: DATA_WIDTH];
      assign lane_flags[gi] = {negative_reg[gi], carry_reg[gi], overflow_reg[gi], zero_reg[gi]};
    end
  endgenerate

  assign draining = (state_reg == DRAIN);
  assign capture  = in_valid && (state_reg == IDLE);
  assign beat     = draining && wb_ready;
  assign mask_clr = mask_reg & (mask_reg - SIMD_WIDTH'(1));

  // Lowest set bit of the remaining mask selects the current lane
  always_comb begin
    cur_lane = '0;
    for (int i = SIMD_WIDTH - 1; i >= 0; i--) begin
      if (mask_reg[i]) cur_lane = LANE_W'(i);
    end
  end

  // Beat payload is only driven while draining; it is a pure function of
  // held registers, so it stays stable across backpressure
  assign wb_data  = draining ? lane_data[cur_lane] : '0;
  assign wb_flags = draining ? lane_flags[cur_lane] : 4'b0000;
  assign wb_lane  = draining ? cur_lane : '0;
  assign wb_rd    = draining ? (rd_base_reg + REG_ADDR_WIDTH'(cur_lane)) : '0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and handshake/status outputs
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    wb_valid   = 1'b0;
    vec_done   = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = (|in_lane_mask) ? DRAIN : DONE;
      end
      DRAIN: begin
        wb_valid = 1'b1;
        if (wb_ready && (mask_clr == '0)) state_next = DONE;
      end
      DONE: begin
        vec_done   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture registers; the remaining mask sheds one lane per accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg   <= '0;
      zero_reg     <= '0;
      overflow_reg <= '0;
      carry_reg    <= '0;
      negative_reg <= '0;
      mask_reg     <= '0;
      rd_base_reg  <= '0;
    end else if (capture) begin
      result_reg   <= in_result;
      zero_reg     <= in_zero;
      overflow_reg <= in_overflow;
      carry_reg    <= in_carry_out;
      negative_reg <= in_negative;
      mask_reg     <= in_lane_mask;
      rd_base_reg  <= in_rd_base;
    end else if (beat) begin
      mask_reg <= mask_clr;
    end
  end

`ifdef SIMD_SER_STICKY_FLAGS_EN
  logic any_overflow_reg;
  logic any_carry_reg;
  logic any_negative_reg;
  logic all_zero_reg;

  // Flag summary over written lanes: cleared on capture, folded in per beat.
  // all_zero starts at 1 so an empty mask reports all-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_overflow_reg <= 1'b0;
      any_carry_reg    <= 1'b0;
      any_negative_reg <= 1'b0;
      all_zero_reg     <= 1'b0;
    end else if (capture) begin
      any_overflow_reg <= 1'b0;
      any_carry_reg    <= 1'b0;
      any_negative_reg <= 1'b0;
      all_zero_reg     <= 1'b1;
    end else if (beat) begin
      any_overflow_reg <= any_overflow_reg | overflow_reg[cur_lane];
      any_carry_reg    <= any_carry_reg    | carry_reg[cur_lane];
      any_negative_reg <= any_negative_reg | negative_reg[cur_lane];
      all_zero_reg     <= all_zero_reg     & zero_reg[cur_lane];
    end
  end

  assign vec_any_overflow = vec_done & any_overflow_reg;
  assign vec_any_carry    = vec_done & any_carry_reg;
  assign vec_any_negative = vec_done & any_negative_reg;
  assign vec_all_zero     = vec_done & all_zero_reg;
`endif

endmodule

// File: tb/tb_simd_result_serializer.sv
// Directed bench for simd_result_serializer: a vector table drained with
// wb_ready held high, plus hand-written backpressure and reset sequences.
module tb_simd_result_serializer;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_result;
  logic [3:0]   in_zero, in_overflow, in_carry_out, in_negative, in_lane_mask;
  logic [4:0]   in_rd_base;
  logic         wb_valid, wb_ready;
  logic [31:0]  wb_data;
  logic [4:0]   wb_rd;
  logic [1:0]   wb_lane;
  logic [3:0]   wb_flags;
  logic         vec_done, busy;
`ifdef SIMD_SER_STICKY_FLAGS_EN
  logic vec_any_overflow, vec_any_carry, vec_any_negative, vec_all_zero;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  simd_result_serializer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_zero      (in_zero),
    .in_overflow  (in_overflow),
    .in_carry_out (in_carry_out),
    .in_negative  (in_negative),
    .in_lane_mask (in_lane_mask),
    .in_rd_base   (in_rd_base),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .wb_lane      (wb_lane),
    .wb_flags     (wb_flags),
    .vec_done     (vec_done),
    .busy         (busy)
`ifdef SIMD_SER_STICKY_FLAGS_EN
    ,
    .vec_any_overflow (vec_any_overflow),
    .vec_any_carry    (vec_any_carry),
    .vec_any_negative (vec_any_negative),
    .vec_all_zero     (vec_all_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0]       result;
    logic [3:0]         z, v, c, n, mask;
    logic [4:0]         base;
    int                 k;
    logic [3:0][4:0]    exp_rd;
    logic [3:0][1:0]    exp_lane;
    logic [3:0][31:0]   exp_data;
    logic [3:0][3:0]    exp_flags;
    logic [3:0]         exp_sticky;   // {any_neg, any_carry, any_ovf, all_zero}
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_vec(input logic [127:0] r, input logic [3:0] z, v, c, n, m,
                           input logic [4:0] b);
    in_result    = r;
    in_zero      = z;
    in_overflow  = v;
    in_carry_out = c;
    in_negative  = n;
    in_lane_mask = m;
    in_rd_base   = b;
    in_valid     = 1'b1;
  endtask

  task automatic run_vec(input int idx);
    vec_t t;
    t = tbl[idx];
    @(negedge clk);
    wb_ready = 1'b1;
    drive_vec(t.result, t.z, t.v, t.c, t.n, t.mask, t.base);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int b = 0; b < t.k; b++) begin
      @(negedge clk);
      check($sformatf("v%0d_b%0d_valid", idx, b), 64'(wb_valid), 64'd1);
      check($sformatf("v%0d_b%0d_rd", idx, b), 64'(wb_rd), 64'(t.exp_rd[b]));
      check($sformatf("v%0d_b%0d_lane", idx, b), 64'(wb_lane), 64'(t.exp_lane[b]));
      check($sformatf("v%0d_b%0d_data", idx, b), 64'(wb_data), 64'(t.exp_data[b]));
      check($sformatf("v%0d_b%0d_flags", idx, b), 64'(wb_flags), 64'(t.exp_flags[b]));
      check($sformatf("v%0d_b%0d_inrdy", idx, b), 64'(in_ready), 64'd0);
      $display("vec %0d beat %0d: rd=%0d lane=%0d data=%0h flags=%b", idx, b, wb_rd, wb_lane, wb_data, wb_flags);
    end
    @(negedge clk);
    check($sformatf("v%0d_done", idx), 64'(vec_done), 64'd1);
    check($sformatf("v%0d_done_nowb", idx), 64'(wb_valid), 64'd0);
    check($sformatf("v%0d_done_inrdy", idx), 64'(in_ready), 64'd0);
`ifdef SIMD_SER_STICKY_FLAGS_EN
    check($sformatf("v%0d_sticky", idx),
          64'({vec_any_negative, vec_any_carry, vec_any_overflow, vec_all_zero}), 64'(t.exp_sticky));
`endif
    @(negedge clk);
    check($sformatf("v%0d_idle_inrdy", idx), 64'(in_ready), 64'd1);
    check($sformatf("v%0d_idle_done", idx), 64'(vec_done), 64'd0);
    check($sformatf("v%0d_idle_busy", idx), 64'(busy), 64'd0);
    $display("vec %0d drained: %0d beats, mask=%b base=%0d", idx, t.k, t.mask, t.base);
  endtask

  initial begin
    // Full mask, no backpressure
    tbl[0].result = {32'h44, 32'h33, 32'h22, 32'h11};
    tbl[0].z = 4'b0000; tbl[0].v = 4'b0000; tbl[0].c = 4'b0000; tbl[0].n = 4'b0000;
    tbl[0].mask = 4'b1111; tbl[0].base = 5'd8; tbl[0].k = 4;
    tbl[0].exp_rd    = {5'd11, 5'd10, 5'd9, 5'd8};
    tbl[0].exp_lane  = {2'd3, 2'd2, 2'd1, 2'd0};
    tbl[0].exp_data  = {32'h44, 32'h33, 32'h22, 32'h11};
    tbl[0].exp_flags = '0;
    tbl[0].exp_sticky = 4'b0000;
    // Register wrap and flags
    tbl[1].result = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    tbl[1].z = 4'b1000; tbl[1].v = 4'b0000; tbl[1].c = 4'b0000; tbl[1].n = 4'b0100;
    tbl[1].mask = 4'b1100; tbl[1].base = 5'd30; tbl[1].k = 2;
    tbl[1].exp_rd    = {5'd0, 5'd0, 5'd1, 5'd0};
    tbl[1].exp_lane  = {2'd0, 2'd0, 2'd3, 2'd2};
    tbl[1].exp_data  = {32'h0, 32'h0, 32'hA3, 32'hA2};
    tbl[1].exp_flags = {4'b0000, 4'b0000, 4'b0001, 4'b1000};
    tbl[1].exp_sticky = 4'b1000;
    // Sticky flag summary over lanes 0..1
    tbl[2].result = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    tbl[2].z = 4'b0011; tbl[2].v = 4'b0001; tbl[2].c = 4'b0000; tbl[2].n = 4'b0000;
    tbl[2].mask = 4'b0011; tbl[2].base = 5'd0; tbl[2].k = 2;
    tbl[2].exp_rd    = {5'd0, 5'd0, 5'd1, 5'd0};
    tbl[2].exp_lane  = {2'd0, 2'd0, 2'd1, 2'd0};
    tbl[2].exp_data  = {32'h0, 32'h0, 32'hC1, 32'hC0};
    tbl[2].exp_flags = {4'b0000, 4'b0000, 4'b0001, 4'b0011};
    tbl[2].exp_sticky = 4'b0011;
    // Empty mask: flags of unwritten lanes must not leak into the summary
    tbl[3].result = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
    tbl[3].z = 4'b0000; tbl[3].v = 4'b1111; tbl[3].c = 4'b1111; tbl[3].n = 4'b1111;
    tbl[3].mask = 4'b0000; tbl[3].base = 5'd3; tbl[3].k = 0;
    tbl[3].exp_rd = '0; tbl[3].exp_lane = '0; tbl[3].exp_data = '0; tbl[3].exp_flags = '0;
    tbl[3].exp_sticky = 4'b0001;
    // Sparse 0101 with a skipped lane whose zero flag is set
    tbl[4].result = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    tbl[4].z = 4'b0010; tbl[4].v = 4'b0000; tbl[4].c = 4'b0100; tbl[4].n = 4'b0000;
    tbl[4].mask = 4'b0101; tbl[4].base = 5'd15; tbl[4].k = 2;
    tbl[4].exp_rd    = {5'd0, 5'd0, 5'd17, 5'd15};
    tbl[4].exp_lane  = {2'd0, 2'd0, 2'd2, 2'd0};
    tbl[4].exp_data  = {32'h0, 32'h0, 32'hD2, 32'hD0};
    tbl[4].exp_flags = {4'b0000, 4'b0000, 4'b0100, 4'b0000};
    tbl[4].exp_sticky = 4'b0100;

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
    drive_vec('0, '0, '0, '0, '0, '0, '0);
    in_valid = 1'b0;
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_vec_done", 64'(vec_done), 64'd0);
    check("rst_wb_rd", 64'(wb_rd), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(i);

    // Sparse mask with backpressure: lane1 held three cycles, then lane3
    @(negedge clk);
    wb_ready = 1'b0;
    drive_vec({32'hB3, 32'hB2, 32'hB1, 32'hB0}, '0, '0, '0, '0, 4'b1010, 5'd4);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check($sformatf("bp_stall%0d_valid", s), 64'(wb_valid), 64'd1);
      check($sformatf("bp_stall%0d_rd", s), 64'(wb_rd), 64'd5);
      check($sformatf("bp_stall%0d_data", s), 64'(wb_data), 64'hB1);
      check($sformatf("bp_stall%0d_lane", s), 64'(wb_lane), 64'd1);
      $display("bp stall %0d: rd=%0d data=%0h", s, wb_rd, wb_data);
      // Upstream offers a new vector mid-drain; it must be ignored
      if (s == 0) drive_vec('1, '1, '1, '1, '1, 4'b1111, 5'd0);
      if (s == 1) in_valid = 1'b0;
    end
    wb_ready = 1'b1;
    @(negedge clk);
    check("bp_lane3_valid", 64'(wb_valid), 64'd1);
    check("bp_lane3_rd", 64'(wb_rd), 64'd7);
    check("bp_lane3_data", 64'(wb_data), 64'hB3);
    $display("bp beat: rd=%0d data=%0h", wb_rd, wb_data);
    @(negedge clk);
    check("bp_done", 64'(vec_done), 64'd1);
    check("bp_done_nowb", 64'(wb_valid), 64'd0);
    @(negedge clk);
    check("bp_idle_inrdy", 64'(in_ready), 64'd1);

    // Reset mid-DRAIN discards the vector; outputs fall asynchronously
    @(negedge clk);
    drive_vec({32'h44, 32'h33, 32'h22, 32'h11}, '0, '0, '0, '0, 4'b1111, 5'd8);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("rmd_b0_rd", 64'(wb_rd), 64'd8);
    @(negedge clk);
    check("rmd_b1_rd", 64'(wb_rd), 64'd9);
    #1 rst_n = 1'b0;
    #1;
    check("rmd_wb_valid", 64'(wb_valid), 64'd0);
    check("rmd_busy", 64'(busy), 64'd0);
    check("rmd_vec_done", 64'(vec_done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rmd_in_ready", 64'(in_ready), 64'd1);
    $display("reset mid-drain: wb_valid=%0d busy=%0d in_ready=%0d", wb_valid, busy, in_ready);
    @(negedge clk);
    drive_vec({32'h0, 32'h0, 32'h0, 32'hE0}, '0, '0, '0, '0, 4'b0001, 5'd20);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("rmd_new_valid", 64'(wb_valid), 64'd1);
    check("rmd_new_rd", 64'(wb_rd), 64'd20);
    check("rmd_new_data", 64'(wb_data), 64'hE0);
    $display("post-reset beat: rd=%0d data=%0h", wb_rd, wb_data);
    @(negedge clk);
    check("rmd_new_done", 64'(vec_done), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
